// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: round-robin ALU/load arbitration onto the single array write port, plus busy scoreboard.
// Latency: grant in cycle N, registered strobe in N+1. Backpressure: wbN_ready/rsv_ready low holds the requester.
// Optional REGFILE_WB_FORWARD_EN: forwards word strobes to the source-operand query ports.
module regfile_wb_scheduler #(
    parameter int register_num        = 32,
    parameter int register_width      = 32,
    parameter int register_num_length = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rsv_valid,
    input  logic [register_num_length-1:0] rsv_addr,
    output logic                           rsv_ready,
    input  logic                           wb0_valid,
    output logic                           wb0_ready,
    input  logic [register_num_length-1:0] wb0_addr,
    input  logic [register_width-1:0]      wb0_data,
    input  logic                           wb0_byte,
    input  logic                           wb1_valid,
    output logic                           wb1_ready,
    input  logic [register_num_length-1:0] wb1_addr,
    input  logic [register_width-1:0]      wb1_data,
    input  logic                           wb1_byte,
    output logic                           write_word_enable,
    output logic                           write_byte_enable,
    output logic [register_num_length-1:0] write_reg_address,
    output logic [register_width-1:0]      write_data,
    input  logic [register_num_length-1:0] rd1_addr,
    input  logic [register_num_length-1:0] rd2_addr,
    output logic                           rd1_busy,
    output logic                           rd2_busy,
    output logic                           fwd1_valid,
    output logic                           fwd2_valid,
    output logic [register_width-1:0]      fwd1_data,
    output logic [register_width-1:0]      fwd2_data,
    output logic                           err_unreserved
);

    logic [register_num-1:0] busy;
    logic                    last_grant;
    logic                    grant0;
    logic                    grant1;
    logic                    commit;

    // Round-robin: on contention, the requester that did not win last time goes.
    always_comb begin
        grant0 = wb0_valid & (~wb1_valid | last_grant);
        grant1 = wb1_valid & (~wb0_valid | ~last_grant);
    end

    assign wb0_ready = grant0 & ~rst;
    assign wb1_ready = grant1 & ~rst;
    assign rsv_ready = rsv_valid & ~busy[rsv_addr] & ~rst;
    assign commit    = write_word_enable | write_byte_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy              <= '0;
            last_grant        <= 1'b1;
            write_word_enable <= 1'b0;
            write_byte_enable <= 1'b0;
            write_reg_address <= '0;
            write_data        <= '0;
            err_unreserved    <= 1'b0;
        end else begin
            // Clear before set; a busy register never accepts a reservation, so they cannot overlap legally.
            if (commit) begin
                busy[write_reg_address] <= 1'b0;
                if (!busy[write_reg_address]) begin
                    err_unreserved <= 1'b1;
                end
            end
            if (rsv_ready) begin
                busy[rsv_addr] <= 1'b1;
            end
            if (grant0) begin
                write_word_enable <= ~wb0_byte;
                write_byte_enable <= wb0_byte;
                write_reg_address <= wb0_addr;
                write_data        <= wb0_data;
                last_grant        <= 1'b0;
            end else if (grant1) begin
                write_word_enable <= ~wb1_byte;
                write_byte_enable <= wb1_byte;
                write_reg_address <= wb1_addr;
                write_data        <= wb1_data;
                last_grant        <= 1'b1;
            end else begin
                write_word_enable <= 1'b0;
                write_byte_enable <= 1'b0;
            end
        end
    end

`ifdef REGFILE_WB_FORWARD_EN
    logic hit1;
    logic hit2;

    // Only full-word strobes carry a complete operand; byte writes stay busy until committed.
    always_comb begin
        hit1       = write_word_enable & (write_reg_address == rd1_addr) & ~rst;
        hit2       = write_word_enable & (write_reg_address == rd2_addr) & ~rst;
        fwd1_valid = hit1;
        fwd2_valid = hit2;
        fwd1_data  = hit1 ? write_data : '0;
        fwd2_data  = hit2 ? write_data : '0;
        rd1_busy   = busy[rd1_addr] & ~hit1 & ~rst;
        rd2_busy   = busy[rd2_addr] & ~hit2 & ~rst;
    end
`else
    always_comb begin
        fwd1_valid = 1'b0;
        fwd2_valid = 1'b0;
        fwd1_data  = '0;
        fwd2_data  = '0;
        rd1_busy   = busy[rd1_addr] & ~rst;
        rd2_busy   = busy[rd2_addr] & ~rst;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then random traffic against a scoreboard model.
module tb_regfile_wb_scheduler;

`ifdef REGFILE_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        wb0_valid, wb1_valid;
    logic        wb0_ready, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_byte, wb1_byte;
    logic        write_word_enable, write_byte_enable;
    logic [4:0]  write_reg_address;
    logic [31:0] write_data;
    logic [4:0]  rd1_addr, rd2_addr;
    logic        rd1_busy, rd2_busy;
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
    logic        err_unreserved;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr),
        .wb0_data(wb0_data), .wb0_byte(wb0_byte),
        .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr),
        .wb1_data(wb1_data), .wb1_byte(wb1_byte),
        .write_word_enable(write_word_enable), .write_byte_enable(write_byte_enable),
        .write_reg_address(write_reg_address), .write_data(write_data),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
        .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .err_unreserved(err_unreserved)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    // Reference model: which registers have a pending write, who went last, what strobe is on the port.
    bit        mbusy [32];
    bit        m_last;
    bit        m_we, m_be, m_err;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit        e_rsv, e_g0, e_g1;
    logic      o_rsv, o_g0, o_g1, o_rd1b, o_rd2b, o_f1v, o_f2v;
    logic [31:0] o_f2d;

    // One clock cycle: called at the falling edge with inputs already applied.
    task automatic step();
        int gi;
        bit h1, h2;
        #1;
        e_rsv = rsv_valid && !mbusy[rsv_addr] && !rst;
        gi = -1;
        if (!rst) begin
            if (wb0_valid && wb1_valid) gi = m_last ? 0 : 1;
            else if (wb0_valid)         gi = 0;
            else if (wb1_valid)         gi = 1;
        end
        e_g0 = (gi == 0);
        e_g1 = (gi == 1);
        h1 = FWD && !rst && m_we && (m_addr == rd1_addr);
        h2 = FWD && !rst && m_we && (m_addr == rd2_addr);
        o_rsv = rsv_ready; o_g0 = wb0_ready; o_g1 = wb1_ready;
        o_rd1b = rd1_busy; o_rd2b = rd2_busy; o_f1v = fwd1_valid; o_f2v = fwd2_valid; o_f2d = fwd2_data;
        check("rsv_ready", rsv_ready, e_rsv);
        check("wb0_ready", wb0_ready, e_g0);
        check("wb1_ready", wb1_ready, e_g1);
        check("rd1_busy", rd1_busy, !rst && mbusy[rd1_addr] && !h1);
        check("rd2_busy", rd2_busy, !rst && mbusy[rd2_addr] && !h2);
        check("fwd1_valid", fwd1_valid, h1);
        check("fwd2_valid", fwd2_valid, h2);
        check("fwd1_data", fwd1_data, h1 ? m_data : 32'h0);
        check("fwd2_data", fwd2_data, h2 ? m_data : 32'h0);
        @(posedge clk);
        if (rst) begin
            foreach (mbusy[i]) mbusy[i] = 1'b0;
            m_last = 1'b1; m_we = 1'b0; m_be = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
        end else begin
            if (m_we || m_be) begin
                if (!mbusy[m_addr]) m_err = 1'b1;
                mbusy[m_addr] = 1'b0;
            end
            if (e_rsv) mbusy[rsv_addr] = 1'b1;
            if (gi == 0) begin
                m_we = !wb0_byte; m_be = wb0_byte; m_addr = wb0_addr; m_data = wb0_data; m_last = 1'b0;
            end else if (gi == 1) begin
                m_we = !wb1_byte; m_be = wb1_byte; m_addr = wb1_addr; m_data = wb1_data; m_last = 1'b1;
            end else begin
                m_we = 1'b0; m_be = 1'b0;
            end
        end
        #1;
        check("write_word_enable", write_word_enable, m_we);
        check("write_byte_enable", write_byte_enable, m_be);
        check("write_reg_address", write_reg_address, m_addr);
        check("write_data", write_data, m_data);
        check("err_unreserved", err_unreserved, m_err);
        @(negedge clk);
    endtask

    task automatic reserve(input logic [4:0] a);
        rsv_valid = 1'b1; rsv_addr = a;
        step();
        rsv_valid = 1'b0;
    endtask

    logic [4:0] pend[$];

    initial begin
        rst = 1'b1; rsv_valid = 0; rsv_addr = 0;
        wb0_valid = 0; wb0_addr = 0; wb0_data = 0; wb0_byte = 0;
        wb1_valid = 0; wb1_addr = 0; wb1_data = 0; wb1_byte = 0;
        rd1_addr = 0; rd2_addr = 0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Contention: grants alternate starting with req0 after reset.
        for (int a = 1; a <= 4; a++) reserve(5'(a));
        wb0_valid = 1; wb0_addr = 1; wb0_data = 32'h1111_1111;
        wb1_valid = 1; wb1_addr = 2; wb1_data = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            step();
            check("cont_grant0", o_g0, (i % 2) == 0);
            check("cont_grant1", o_g1, (i % 2) == 1);
            check("cont_one_enable", {write_word_enable, write_byte_enable}, 2'b10);
            if (o_g0) begin
                if (wb0_addr == 1) begin wb0_addr = 3; wb0_data = 32'h3333_3333; end
                else wb0_valid = 0;
            end
            if (o_g1) begin
                if (wb1_addr == 2) begin wb1_addr = 4; wb1_data = 32'h4444_4444; end
                else wb1_valid = 0;
            end
        end
        step();

        // Reserve then commit r5.
        rd1_addr = 5;
        reserve(5);
        check("rc_rsv", o_rsv, 1);
        step();
        check("rc_busy", o_rd1b, 1);
        wb0_valid = 1; wb0_addr = 5; wb0_data = 32'hDEAD_BEEF; wb0_byte = 0;
        step();
        wb0_valid = 0;
        check("rc_grant", o_g0, 1);
        check("rc_strobe_we", write_word_enable, 1);
        check("rc_strobe_addr", write_reg_address, 5);
        check("rc_strobe_data", write_data, 32'hDEAD_BEEF);
        step();
        check("rc_busy_strobe", o_rd1b, FWD ? 1'b0 : 1'b1);
        step();
        check("rc_cleared", o_rd1b, 0);

        // WAW: second reservation of r7 refused until r7 commits.
        rsv_valid = 1; rsv_addr = 7;
        step();
        check("waw_first", o_rsv, 1);
        step();
        check("waw_second", o_rsv, 0);
        wb0_valid = 1; wb0_addr = 7; wb0_data = 32'h0000_0077;
        step();
        wb0_valid = 0;
        check("waw_grant_cycle", o_rsv, 0);
        step();
        check("waw_strobe_cycle", o_rsv, 0);
        step();
        check("waw_retry", o_rsv, 1);
        rsv_valid = 0;

        // Byte write via wb1.
        reserve(3);
        rd1_addr = 3;
        wb1_valid = 1; wb1_addr = 3; wb1_data = 32'h1234_5678; wb1_byte = 1;
        step();
        wb1_valid = 0; wb1_byte = 0;
        check("byte_grant", o_g1, 1);
        check("byte_be", write_byte_enable, 1);
        check("byte_we", write_word_enable, 0);
        step();
        check("byte_nofwd", o_f1v, 0);
        check("byte_busy", o_rd1b, 1);

        // Word commit of r9 with r9 queried on port 2.
        reserve(9);
        rd2_addr = 9;
        wb0_valid = 1; wb0_addr = 9; wb0_data = 32'hA5A5_A5A5;
        step();
        wb0_valid = 0;
        step();
        check("fwd2_valid_r9", o_f2v, FWD);
        check("fwd2_data_r9", o_f2d, FWD ? 32'hA5A5_A5A5 : 32'h0);
        check("rd2_busy_r9", o_rd2b, !FWD);

        // Unreserved commit, then reset with a strobe pending.
        wb0_valid = 1; wb0_addr = 12; wb0_data = 32'h0000_000C;
        step();
        wb0_valid = 0;
        step();
        check("err_set", err_unreserved, 1);
        reserve(20);
        wb0_valid = 1; wb0_addr = 20; wb0_data = 32'h0000_0020;
        step();
        wb0_valid = 0;
        check("pending_strobe", write_word_enable, 1);
        rst = 1;
        step();
        rst = 0;
        check("rst_we", write_word_enable, 0);
        check("rst_be", write_byte_enable, 0);
        check("rst_err", err_unreserved, 0);
        rd1_addr = 7; rd2_addr = 20;
        step();
        check("rst_busy7", o_rd1b, 0);
        check("rst_busy20", o_rd2b, 0);
        reserve(7);
        reserve(8);
        wb0_valid = 1; wb0_addr = 7; wb0_data = 32'h7;
        wb1_valid = 1; wb1_addr = 8; wb1_data = 32'h8;
        step();
        check("rst_first_grant", o_g0, 1);
        wb0_valid = 0;
        step();
        wb1_valid = 0;
        step();

        // Random traffic: requesters only write back registers they reserved.
        for (int c = 0; c < 500; c++) begin
            rsv_valid = ($urandom_range(0, 1) == 1);
            rsv_addr  = 5'($urandom_range(0, 31));
            if (!wb0_valid && pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb0_valid = 1; wb0_addr = pend.pop_front(); wb0_data = $urandom;
                wb0_byte = ($urandom_range(0, 3) == 0);
            end
            if (!wb1_valid && pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                wb1_valid = 1; wb1_addr = pend.pop_front(); wb1_data = $urandom;
                wb1_byte = ($urandom_range(0, 3) == 0);
            end
            rd1_addr = 5'($urandom_range(0, 31));
            rd2_addr = ($urandom_range(0, 1) == 1) ? m_addr : 5'($urandom_range(0, 31));
            step();
            if (e_rsv) pend.push_back(rsv_addr);
            if (e_g0) wb0_valid = 0;
            if (e_g1) wb1_valid = 0;
        end
        rsv_valid = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (e_g0) wb0_valid = 0;
            if (e_g1) wb1_valid = 0;
        end
        check("final_no_error", err_unreserved, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32×32 register array. Arbitrates between two write-back requesters (ALU result, memory load) for the register array's single write port. Keeps a per-register busy scoreboard, reserved at issue and cleared on commit, so the issue stage can detect RAW/WAW hazards. Its registered write strobes drive the array's `write_word_enable`, `write_byte_enable`, `write_reg_address` and `write_data` directly.

## Interface
- `register_num`, 32, number of architectural registers
- `register_width`, 32, data width
- `register_num_length`, 5, address width

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `rsv_valid`  in  1  issue stage requests a destination reservation
- `rsv_addr`  in  5  register to reserve
- `rsv_ready`  out  1  reservation accepted this cycle
- `wb0_valid`, `wb1_valid`  in  1  write-back request (0 = ALU, 1 = load)
- `wb0_ready`, `wb1_ready`  out  1  request granted this cycle
- `wb0_addr`, `wb1_addr`  in  5  destination register
- `wb0_data`, `wb1_data`  in  32  write data
- `wb0_byte`, `wb1_byte`  in  1  1 = byte write ([7:0] only), 0 = word write
- `write_word_enable`  out  1  to array
- `write_byte_enable`  out  1  to array
- `write_reg_address`  out  5  to array
- `write_data`  out  32  to array
- `rd1_addr`, `rd2_addr`  in  5  source-operand query addresses
- `rd1_busy`, `rd2_busy`  out  1  source register has a pending write
- `fwd1_valid`, `fwd2_valid`  out  1  forwarded data valid
- `fwd1_data`, `fwd2_data`  out  32  forwarded data
- `err_unreserved`  out  1  sticky: a write committed to a register that was not busy

## Operation
- **State.**
  - `busy[register_num-1:0]`.
  - `last_grant`, 1 bit.
  - Output stage registers: `write_word_enable`, `write_byte_enable`, `write_reg_address`, `write_data`.
  - `err_unreserved`.
- **Reservation.**
  - `rsv_ready = rsv_valid & ~busy[rsv_addr] & ~rst`.
  - On `rsv_ready`, `busy[rsv_addr]` is set at the edge.
  - A reservation to a busy register is refused; the requester holds and retries.
- **Arbitration** (combinational grant, round-robin):
  - Only one `wbN_valid` high: it is granted.
  - Both high: the requester ≠ `last_grant` is granted.
  - `wbN_ready` = grant & ~rst.
  - `last_grant` updates to the granted index on every grant.
- **Output stage.**
  - Grant at edge E: the output registers load addr/data at E. `write_word_enable = ~byte` and `write_byte_enable = byte` for exactly one cycle.
  - No grant: both enables are 0 the next cycle; addr/data hold.
- **Commit.**
  - While either enable is high, `busy[write_reg_address]` clears at the next edge, the same edge at which the array captures the data.
  - If the busy bit is already 0 at that point, `err_unreserved` sets and stays set until `rst`.
  - Set and clear never collide: a busy register refuses reservations.
- **Query.** `rdN_busy = busy[rdN_addr]`, combinational, subject to forwarding (see Configuration).
- **Reset mid-operation.**
  - Clears `busy` and `err_unreserved`, zeroes the enables, and sets `last_grant = 1`.
  - An in-flight strobe is dropped.

## Timing
- **Reset values:**
  - `write_word_enable`, `write_byte_enable` = 0.
  - `write_reg_address`, `write_data` = 0.
  - `rd*_busy`, `fwd*` = 0.
  - `err_unreserved` = 0.
  - `rsv_ready`, `wb*_ready` = 0 while `rst` is high.
- **Latency:** grant at cycle N, strobe high in N+1, array updated and busy cleared at the end of N+1. A read of the array is valid from N+2.
- **Throughput:** one write per cycle. A requester held by round-robin waits at most one cycle.
- **Handshake:** `wbN_valid`, `addr`, `data` and `byte` must hold until `wbN_ready`. Ready never depends on the other requester's data.
- **First grant after reset:** with both requesters valid, req0 is granted.

## Configuration
- `REGFILE_WB_FORWARD_EN` defined:
  - While `write_word_enable` is high and `write_reg_address == rdN_addr`: `fwdN_valid = 1`, `fwdN_data = write_data`, and `rdN_busy` is forced to 0.
  - Byte writes are never forwarded.
- Not defined: `fwdN_valid` and `fwdN_data` are tied to 0, and `rdN_busy` reflects `busy` only, clearing one cycle later than with forwarding.

## Test plan
- **Reserve/commit:**
  - Stimulus: reserve r5, then wb0 word r5 = 0xDEADBEEF.
  - Response: `rsv_ready` = 1; `rd1_busy(r5)` = 1 until commit; strobe one cycle after grant with addr 5 and data 0xDEADBEEF; `busy[5]` = 0 after the strobe edge.
- **Contention:**
  - Stimulus: reserve r1–r4; hold wb0 and wb1 valid for 4 cycles with distinct addresses.
  - Response: grants alternate 0, 1, 0, 1 starting with 0; exactly one enable per cycle.
- **WAW:**
  - Stimulus: reserve r7 twice in consecutive cycles.
  - Response: second `rsv_ready` = 0 until r7 commits, then 1.
- **Byte write:**
  - Stimulus: reserve r3; wb1 byte r3, data 0x12345678.
  - Response: `write_byte_enable` = 1, `write_word_enable` = 0; with forwarding enabled, `fwd1_valid` stays 0.
- **Forwarding** (macro on):
  - Stimulus: `rd2_addr` = 9 during word commit of r9 = 0xA5A5A5A5.
  - Response: `fwd2_valid` = 1, `fwd2_data` = 0xA5A5A5A5, `rd2_busy` = 0 in that cycle.
- **Error/reset:**
  - Stimulus: commit to unreserved r12; then assert `rst` with a strobe pending.
  - Response: `err_unreserved` = 1 after the commit; after `rst`, all busy bits, enables and `err_unreserved` = 0, and the next dual request grants req0.
